// File: rtl/config_scheduler_pkg.sv
// Shared types and constants for the sensor configuration scheduler.
//   - cfg_state_t : scheduler FSM states
//   - sched_reg_t : registered outputs of the scheduler, kept together
//   - ps/ns/us -> clock-cycle conversion (ceil), usable in constant context
package config_scheduler_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_WIN,
        ST_SEND,
        ST_WAIT_ACK,
        ST_FAILED_ATTEMPT,
        ST_FAIL
    } cfg_state_t;

    typedef struct packed {
        logic               tx_start;
        logic               snapshot;
        logic               pending;
        logic               fail;
        logic [RETRY_W-1:0] retry_cnt;
    } sched_reg_t;

    // Round up so a timeout is never shorter than the requested time.
    function automatic int unsigned ps_to_cycles(input longint unsigned t_ps,
                                                 input longint unsigned period_ps);
        longint unsigned c;
        c = (t_ps + period_ps - 64'd1) / period_ps;
        return c[31:0];
    endfunction

    function automatic int unsigned ns_to_cycles(input longint unsigned t_ns,
                                                 input longint unsigned period_ps);
        return ps_to_cycles(t_ns * 64'd1000, period_ps);
    endfunction

    function automatic int unsigned us_to_cycles(input longint unsigned t_us,
                                                 input longint unsigned period_ps);
        return ps_to_cycles(t_us * 64'd1000000, period_ps);
    endfunction

endpackage

// File: rtl/config_scheduler_if.sv
// Handshake bundle between the config scheduler and its neighbours
// (I2C register file, serial config transmitter, synchronised decoder status).
//   inputs to scheduler : reg_we, force_cfg, cfg_window, frame_start, tx_end (1-cycle pulses)
//   outputs of scheduler: tx_start, snapshot (pulses), cfg_pending, cfg_busy, cfg_fail, retry_cnt
// master = scheduler side, slave = environment side.
interface config_scheduler_if;
    import config_scheduler_pkg::*;

    logic               reg_we;
    logic               force_cfg;
    logic               cfg_window;
    logic               frame_start;
    logic               tx_end;
    logic               tx_start;
    logic               snapshot;
    logic               cfg_pending;
    logic               cfg_busy;
    logic               cfg_fail;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        input  reg_we, force_cfg, cfg_window, frame_start, tx_end,
        output tx_start, snapshot, cfg_pending, cfg_busy, cfg_fail, retry_cnt
    );

    modport slave (
        output reg_we, force_cfg, cfg_window, frame_start, tx_end,
        input  tx_start, snapshot, cfg_pending, cfg_busy, cfg_fail, retry_cnt
    );

endinterface

// File: rtl/config_scheduler_cfg_timer.sv
// Loadable down-counter used for timeouts.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over counting)
//   load_val   : timeout length in cycles
//   en         : count down while high
//   expire     : 1-cycle pulse in the last counted cycle
// The counter saturates at 0, so expire fires only once per load.
module cfg_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A load in the same cycle restarts the timeout, so it masks expiry.
    assign expire = en && !load && (cnt == W'(1));

endmodule

// File: rtl/config_scheduler.sv
// Sensor configuration upload sequencer.
// Tracks dirty registers, waits for the sensor config window, fires the config
// transmitter once (with a register-file shadow snapshot), then checks that the
// sensor resumes framing. Failed attempts are retried up to MAX_RETRY, after
// which a sticky failure is flagged until a new write or forced resend.
//   clk, rst_n : system clock, async active-low reset
//   bus        : config_scheduler_if.master (see interface for signal list)
// All outputs are registered: 1-cycle latency from the triggering input.
module config_scheduler
    import config_scheduler_pkg::*;
#(
    parameter int unsigned CLOCK_PERIOD_PS    = 20833,
    parameter int unsigned TX_TIMEOUT_NS      = 20000,
    parameter int unsigned FRAME_TIMEOUT_US   = 100000,
    parameter int unsigned WIN_TIMEOUT_FRAMES = 4,
    parameter int unsigned ACK_FRAMES         = 2,
    parameter int unsigned MAX_RETRY          = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    config_scheduler_if.master bus
);

    localparam int unsigned TX_CYC  = ns_to_cycles(64'(TX_TIMEOUT_NS), 64'(CLOCK_PERIOD_PS));
    localparam int unsigned FRM_CYC = us_to_cycles(64'(FRAME_TIMEOUT_US), 64'(CLOCK_PERIOD_PS));
    localparam int          TX_W    = $clog2(TX_CYC) + 1;
    localparam int          FRM_W   = $clog2(FRM_CYC) + 1;
    localparam int unsigned CNT_MAX = (ACK_FRAMES > WIN_TIMEOUT_FRAMES) ? ACK_FRAMES
                                                                        : WIN_TIMEOUT_FRAMES;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);

    localparam sched_reg_t REG_RST = '{tx_start:  1'b0,
                                       snapshot:  1'b0,
                                       pending:   1'b1,
                                       fail:      1'b0,
                                       retry_cnt: '0};

    cfg_state_t         state_q, state_d;
    sched_reg_t         r_q, r_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   fcnt_inc;
    logic [RETRY_W-1:0] retry_inc;
    logic               wr;
    logic               tx_load, tx_expire;
    logic               frm_load, frm_expire;

    assign wr        = bus.reg_we | bus.force_cfg;
    assign fcnt_inc  = fcnt_q + 1'b1;
    assign retry_inc = r_q.retry_cnt + 1'b1;

    // upload timeout: runs from TX_START until TX_END
    cfg_timer #(.W(TX_W)) u_tx_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load),
        .load_val (TX_W'(TX_CYC)),
        .en       (state_q == ST_SEND),
        .expire   (tx_expire)
    );

    // frame timeout: restarted by TX_END and by every FRAME_START while acking
    cfg_timer #(.W(FRM_W)) u_frm_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (frm_load),
        .load_val (FRM_W'(FRM_CYC)),
        .en       (state_q == ST_WAIT_ACK),
        .expire   (frm_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= REG_RST;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        r_d.tx_start = 1'b0;
        r_d.snapshot = 1'b0;
        fcnt_d       = fcnt_q;
        tx_load      = 1'b0;
        frm_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (r_q.pending) begin
                    state_d = ST_WAIT_WIN;
                    fcnt_d  = '0;
                end
            end

            // Window beats a coincident frame start.
            ST_WAIT_WIN: begin
                if (bus.cfg_window) begin
                    state_d      = ST_SEND;
                    r_d.tx_start = 1'b1;
                    r_d.snapshot = 1'b1;
                    r_d.pending  = 1'b0;
                    tx_load      = 1'b1;
                end else if (bus.frame_start) begin
                    if (fcnt_inc == CNT_W'(WIN_TIMEOUT_FRAMES)) begin
                        state_d = ST_FAILED_ATTEMPT;
                    end else begin
                        fcnt_d = fcnt_inc;
                    end
                end
            end

            // Windows are not looked at here, so a stray one cannot retrigger.
            ST_SEND: begin
                if (bus.tx_end) begin
                    state_d  = ST_WAIT_ACK;
                    fcnt_d   = '0;
                    frm_load = 1'b1;
                end else if (tx_expire) begin
                    state_d = ST_FAILED_ATTEMPT;
                end
            end

            ST_WAIT_ACK: begin
                if (bus.frame_start) begin
                    if (fcnt_inc == CNT_W'(ACK_FRAMES)) begin
                        state_d       = ST_IDLE;
                        r_d.retry_cnt = '0;
                    end else begin
                        fcnt_d   = fcnt_inc;
                        frm_load = 1'b1;
                    end
                end else if (frm_expire) begin
                    state_d = ST_FAILED_ATTEMPT;
                end
            end

            ST_FAILED_ATTEMPT: begin
                r_d.pending   = 1'b1;
                r_d.retry_cnt = retry_inc;
                if (retry_inc == RETRY_W'(MAX_RETRY)) begin
                    state_d = ST_FAIL;
                    r_d.fail = 1'b1;
                end else begin
                    state_d = ST_WAIT_WIN;
                    fcnt_d  = '0;
                end
            end

            ST_FAIL: begin
                if (wr) begin
                    state_d       = ST_WAIT_WIN;
                    r_d.fail      = 1'b0;
                    r_d.retry_cnt = '0;
                    fcnt_d        = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // A write concurrent with the snapshot may not be captured, so it wins.
        if (wr) r_d.pending = 1'b1;
    end

    assign bus.tx_start    = r_q.tx_start;
    assign bus.snapshot    = r_q.snapshot;
    assign bus.cfg_pending = r_q.pending;
    assign bus.cfg_fail    = r_q.fail;
    assign bus.retry_cnt   = r_q.retry_cnt;
    assign bus.cfg_busy    = (state_q != ST_IDLE) && (state_q != ST_FAIL);

endmodule

// File: tb/tb_config_scheduler.sv
// Self-checking bench for config_scheduler: directed scenarios with literal
// expectations plus a long randomized run, all checked every cycle against a
// behavioural model that works with absolute-cycle deadlines.
module tb_config_scheduler;
    import config_scheduler_pkg::*;

    localparam int PER_PS = 20833;
    localparam int TX_NS  = 2000;
    localparam int FRM_US = 10;
    localparam int WIN_TO = 4;
    localparam int ACK_N  = 2;
    localparam int MAXR   = 3;
    localparam int TX_CYC  = (TX_NS * 1000 + PER_PS - 1) / PER_PS;
    localparam int FRM_CYC = (FRM_US * 1000000 + PER_PS - 1) / PER_PS;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #10 clk = ~clk;

    config_scheduler_if bus();

    config_scheduler #(
        .CLOCK_PERIOD_PS    (PER_PS),
        .TX_TIMEOUT_NS      (TX_NS),
        .FRAME_TIMEOUT_US   (FRM_US),
        .WIN_TIMEOUT_FRAMES (WIN_TO),
        .ACK_FRAMES         (ACK_N),
        .MAX_RETRY          (MAXR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_WIN, M_SEND, M_ACK, M_BAD, M_FAIL} ph_t;
    ph_t  ph     = M_IDLE;
    int   mcyc   = 0;
    int   nfr    = 0;
    int   tx_dl  = 0;
    int   frm_dl = 0;
    logic e_tx   = 1'b0;
    logic e_snap = 1'b0;
    logic e_pend = 1'b1;
    logic e_fail = 1'b0;
    int   e_retry = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = M_IDLE; e_tx = 1'b0; e_snap = 1'b0; e_pend = 1'b1;
            e_fail = 1'b0; e_retry = 0; nfr = 0;
        end else begin
            e_tx = 1'b0;
            e_snap = 1'b0;
            case (ph)
                M_IDLE: if (e_pend) begin ph = M_WIN; nfr = 0; end
                M_WIN: begin
                    if (bus.cfg_window) begin
                        ph = M_SEND; e_tx = 1'b1; e_snap = 1'b1; e_pend = 1'b0;
                        tx_dl = mcyc + TX_CYC;
                    end else if (bus.frame_start) begin
                        nfr++;
                        if (nfr == WIN_TO) ph = M_BAD;
                    end
                end
                M_SEND: begin
                    if (bus.tx_end) begin
                        ph = M_ACK; nfr = 0; frm_dl = mcyc + FRM_CYC;
                    end else if (mcyc == tx_dl) begin
                        ph = M_BAD;
                    end
                end
                M_ACK: begin
                    if (bus.frame_start) begin
                        nfr++;
                        if (nfr == ACK_N) begin ph = M_IDLE; e_retry = 0; end
                        else frm_dl = mcyc + FRM_CYC;
                    end else if (mcyc == frm_dl) begin
                        ph = M_BAD;
                    end
                end
                M_BAD: begin
                    e_pend = 1'b1;
                    e_retry++;
                    if (e_retry == MAXR) begin ph = M_FAIL; e_fail = 1'b1; end
                    else begin ph = M_WIN; nfr = 0; end
                end
                M_FAIL: begin
                    if (bus.reg_we || bus.force_cfg) begin
                        ph = M_WIN; e_fail = 1'b0; e_retry = 0; nfr = 0;
                    end
                end
                default: ph = M_IDLE;
            endcase
            if (bus.reg_we || bus.force_cfg) e_pend = 1'b1;
            mcyc++;
        end
    end

    always @(negedge clk) begin
        cmp("tx_start",  32'(bus.tx_start),    32'(e_tx));
        cmp("snapshot",  32'(bus.snapshot),    32'(e_snap));
        cmp("pending",   32'(bus.cfg_pending), 32'(e_pend));
        cmp("busy",      32'(bus.cfg_busy),    32'(ph != M_IDLE && ph != M_FAIL));
        cmp("cfg_fail",  32'(bus.cfg_fail),    32'(e_fail));
        cmp("retry_cnt", 32'(bus.retry_cnt),   32'(e_retry));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic fc, input logic win,
                         input logic fs, input logic te);
        bus.reg_we = we; bus.force_cfg = fc; bus.cfg_window = win;
        bus.frame_start = fs; bus.tx_end = te;
        tick();
        bus.reg_we = 1'b0; bus.force_cfg = 1'b0; bus.cfg_window = 1'b0;
        bus.frame_start = 1'b0; bus.tx_end = 1'b0;
    endtask

    task automatic wait_retry(input int target, input int bound, output int k);
        k = 0;
        while (32'(bus.retry_cnt) != target && k < bound) begin
            tick();
            k++;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        int k, k2, cnt;
        bus.reg_we = 1'b0; bus.force_cfg = 1'b0; bus.cfg_window = 1'b0;
        bus.frame_start = 1'b0; bus.tx_end = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        cmp("rst_pending", 32'(bus.cfg_pending), 1);
        cmp("rst_busy",    32'(bus.cfg_busy), 0);
        rst_n = 1'b1;                       // cycle 0

        // power-up upload: window in cycle 10 -> TX_START in cycle 11
        repeat (10) tick();
        drive(0, 0, 1, 0, 0);
        cmp("pu_tx_start", 32'(bus.tx_start), 1);
        cmp("pu_snapshot", 32'(bus.snapshot), 1);
        cmp("pu_pending",  32'(bus.cfg_pending), 0);
        repeat (5) tick();
        drive(0, 0, 0, 0, 1);
        repeat (10) tick();
        drive(0, 0, 0, 1, 0);
        repeat (10) tick();
        drive(0, 0, 0, 1, 0);
        cmp("pu_busy_done", 32'(bus.cfg_busy), 0);

        // three TX timeouts -> sticky failure
        drive(0, 1, 0, 0, 0);
        repeat (3) tick();
        for (int a = 1; a <= MAXR; a++) begin
            drive(0, 0, 1, 0, 0);
            cmp("txto_start", 32'(bus.tx_start), 1);
            wait_retry(a, 300, k);
            cmp("txto_latency", k, 98);
            cmp("txto_pending", 32'(bus.cfg_pending), 1);
        end
        cmp("fail_set",  32'(bus.cfg_fail), 1);
        cmp("fail_busy", 32'(bus.cfg_busy), 0);
        repeat (5) tick();
        cmp("fail_sticky", 32'(bus.cfg_fail), 1);
        drive(0, 1, 0, 0, 0);
        cmp("force_clr_fail",  32'(bus.cfg_fail), 0);
        cmp("force_clr_retry", 32'(bus.retry_cnt), 0);
        cmp("force_busy",      32'(bus.cfg_busy), 1);

        // frame loss after TX_END
        repeat (2) tick();
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        wait_retry(1, 700, k2);
        cmp("frmto_latency", 1 + k2, 483);

        // register write during WAIT_ACK
        drive(0, 0, 1, 0, 0);
        cmp("ack_tx_start", 32'(bus.tx_start), 1);
        repeat (3) tick();
        drive(0, 0, 0, 0, 1);
        repeat (5) tick();
        drive(0, 0, 0, 1, 0);
        repeat (3) tick();
        drive(1, 0, 0, 0, 0);
        repeat (3) tick();
        drive(0, 0, 0, 1, 0);
        cmp("ack_retry_clr", 32'(bus.retry_cnt), 0);
        cmp("ack_pending",   32'(bus.cfg_pending), 1);
        tick();
        drive(0, 0, 1, 0, 0);
        cmp("second_upload", 32'(bus.tx_start), 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        cmp("second_done_pending", 32'(bus.cfg_pending), 0);

        // write concurrent with accepted window
        drive(0, 1, 0, 0, 0);
        repeat (2) tick();
        drive(1, 0, 1, 0, 0);
        cmp("conc_tx_start", 32'(bus.tx_start), 1);
        cmp("conc_pending",  32'(bus.cfg_pending), 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        cmp("conc_followup", 32'(bus.tx_start), 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);

        // window timeout, then window+frame tie
        drive(0, 1, 0, 0, 0);
        repeat (2) tick();
        for (int f = 0; f < WIN_TO; f++) drive(0, 0, 0, 1, 0);
        tick();
        cmp("winto_retry", 32'(bus.retry_cnt), 1);
        for (int f = 0; f < WIN_TO - 1; f++) drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 1, 0);
        cmp("tie_window_wins", 32'(bus.tx_start), 1);

        // stray window in SEND, then reset mid-SEND
        tick();
        drive(0, 0, 1, 0, 0);
        cmp("stray_window", 32'(bus.tx_start), 0);
        rst_n = 1'b0;
        tick();
        cmp("midrst_pending", 32'(bus.cfg_pending), 1);
        cmp("midrst_retry",   32'(bus.retry_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.tx_start) cnt++;
        end
        cmp("midrst_no_tx", cnt, 0);
        cmp("midrst_busy",  32'(bus.cfg_busy), 1);
        drive(0, 0, 1, 0, 0);
        cmp("midrst_tx", 32'(bus.tx_start), 1);

        // randomized traffic, second half with a flaky transmitter
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(2999) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(3, 1)) tick();
                rst_n = 1'b1;
            end
            bus.reg_we      = ($urandom_range(199) == 0);
            bus.force_cfg   = ($urandom_range(399) == 0);
            bus.cfg_window  = ($urandom_range(39) == 0);
            bus.frame_start = ($urandom_range(59) == 0);
            bus.tx_end      = (i < 10000) ? ($urandom_range(49) == 0)
                                          : ($urandom_range(499) == 0);
            tick();
        end
        bus.reg_we = 1'b0; bus.force_cfg = 1'b0; bus.cfg_window = 1'b0;
        bus.frame_start = 1'b0; bus.tx_end = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
